logic_capture: RTL and testbench

- Acquisition stage directly upstream of the LogicSlice waveform renderer.
- Samples CH_NUM logic inputs at a programmable rate into a DEPTH-entry circular buffer, with pre-trigger history.
- Holds capture until a trigger condition on one channel, then fills the post-trigger part.
- Rotates the buffer so entry 0 is the oldest sample, then presents the selected channel as the bit array ch[DEPTH] plus valid-sample count np for the renderer.

---
 rtl/logic_capture_pkg.sv | 23 ++
 rtl/logic_capture_if.sv | 30 +++
 rtl/logic_capture_tick.sv | 26 ++
 rtl/logic_capture.sv | 162 ++++++++++++++++
 tb/tb_logic_capture.sv | 183 ++++++++++++++++++
 5 files changed

// File: rtl/logic_capture_pkg.sv
// Shared types and defaults for the logic capture stage and the LogicSlice renderer.
package pkg_capture;

  typedef enum logic [1:0] {TM_IMM, TM_RISE, TM_FALL, TM_ANY} trig_mode_t;

  typedef enum logic [2:0] {C_IDLE, C_PRE, C_WAIT, C_POST, C_ALIGN, C_DONE} cap_state_t;

  localparam int DEFAULT_CH_NUM    = 8;
  localparam int DEFAULT_DEPTH     = 960;
  localparam int DEFAULT_PRE_DEPTH = 96;

  function automatic logic trig_fire(trig_mode_t mode, logic prev, logic cur);
    logic fire;
    case (mode)
      TM_IMM:  fire = 1'b1;
      TM_RISE: fire = !prev && cur;
      TM_FALL: fire = prev && !cur;
      default: fire = prev != cur;
    endcase
    return fire;
  endfunction

endpackage

// File: rtl/logic_capture_if.sv
// Control/status bundle between the capture stage and its host/renderer.
interface logic_capture_if #(
  parameter int CH_NUM = pkg_capture::DEFAULT_CH_NUM,
  parameter int DEPTH  = pkg_capture::DEFAULT_DEPTH
) ();
  localparam int CHW = (CH_NUM > 1) ? $clog2(CH_NUM) : 1;

  logic [CH_NUM-1:0]       din;
  logic                    arm;
  logic                    stop;
  logic [CHW-1:0]          trig_ch;
  pkg_capture::trig_mode_t trig_mode;
  logic [15:0]             div;
  logic [CHW-1:0]          rd_ch;
  logic                    ch [DEPTH];
  logic [9:0]              np;
  logic                    busy;
  logic                    done;
  logic                    trig_seen;

  modport master (
    output din, arm, stop, trig_ch, trig_mode, div, rd_ch,
    input  ch, np, busy, done, trig_seen
  );

  modport slave (
    input  din, arm, stop, trig_ch, trig_mode, div, rd_ch,
    output ch, np, busy, done, trig_seen
  );
endinterface

// File: rtl/logic_capture_tick.sv
// Sample-rate divider: one tick every div+1 enabled clocks, restartable via clr_i.
module capture_tick (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clr_i,
  input  logic        en_i,
  input  logic [15:0] div_i,
  output logic        tick_o
);
  logic [15:0] count_q, count_d;

  assign tick_o = en_i && (count_q == div_i);

  // NOTE: default assigned first so every path writes count_d; no latch.
  always_comb begin
    count_d = count_q;
    if (clr_i)     count_d = '0;
    else if (en_i) count_d = tick_o ? '0 : count_q + 16'd1;
  end

  // NOTE: state registers use non-blocking assignments only.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) count_q <= '0;
    else        count_q <= count_d;
  end
endmodule

// File: rtl/logic_capture.sv
// Triggered circular-buffer capture with pre-trigger history; rotates so entry 0 is oldest.
module logic_capture
  import pkg_capture::*;
#(
  parameter int CH_NUM    = DEFAULT_CH_NUM,
  parameter int DEPTH     = DEFAULT_DEPTH,
  parameter int PRE_DEPTH = DEFAULT_PRE_DEPTH
) (
  input  logic           clk,
  input  logic           rst_n,
  logic_capture_if.slave bus
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  typedef logic [AW-1:0] addr_t;
  typedef logic [CW-1:0] cnt_t;
  localparam addr_t LAST     = addr_t'(DEPTH - 1);
  localparam cnt_t  FULL     = cnt_t'(DEPTH);
  localparam cnt_t  PRE_CNT  = cnt_t'(PRE_DEPTH);
  localparam cnt_t  POST_CNT = cnt_t'(DEPTH - PRE_DEPTH);

  cap_state_t        state_q, state_d;
  addr_t             wp_q, wp_d, rot_q, rot_d, wp_next, wr_ptr;
  cnt_t              written_q, written_d, post_q, post_d, written_next, wr_cnt;
  logic [9:0]        np_q, np_d;
  logic              trig_seen_q, trig_seen_d, prev_trig_q, prev_trig_d;
  logic              busy_q, busy_d, done_q, done_d;
  logic              tick, tick_clr, tick_en, mem_shift, cur;
  logic [CH_NUM-1:0] mem_q [DEPTH];

  assign cur          = bus.din[bus.trig_ch];
  assign tick_en      = state_q inside {C_PRE, C_WAIT, C_POST};
  assign wp_next      = (wp_q == LAST) ? '0 : wp_q + 1'b1;
  assign written_next = (written_q == FULL) ? FULL : written_q + 1'b1;
  // Pointer/count as they stand after this cycle's write (if any).
  assign wr_ptr       = tick ? wp_next : wp_q;
  assign wr_cnt       = tick ? written_next : written_q;

  capture_tick u_tick (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr_i  (tick_clr),
    .en_i   (tick_en),
    .div_i  (bus.div),
    .tick_o (tick)
  );

  always_comb begin
    state_d     = state_q;
    wp_d        = wp_q;
    written_d   = written_q;
    post_d      = post_q;
    rot_d       = rot_q;
    np_d        = np_q;
    trig_seen_d = trig_seen_q;
    prev_trig_d = prev_trig_q;
    tick_clr    = 1'b0;
    mem_shift   = 1'b0;
    case (state_q)
      C_IDLE, C_DONE: begin
        if (bus.arm) begin
          state_d     = C_PRE;
          wp_d        = '0;
          written_d   = '0;
          post_d      = '0;
          rot_d       = '0;
          np_d        = '0;
          trig_seen_d = 1'b0;
          prev_trig_d = 1'b0;
          tick_clr    = 1'b1;
        end
      end
      C_PRE, C_WAIT, C_POST: begin
        if (tick) begin
          wp_d        = wp_next;
          written_d   = written_next;
          prev_trig_d = cur;
        end
        // Stop outranks a trigger on the same tick; that tick's sample is kept.
        if (bus.stop) begin
          state_d = C_ALIGN;
          np_d    = 10'(wr_cnt);
          rot_d   = (wr_cnt == FULL) ? wr_ptr : '0;
        end else if (tick) begin
          if (state_q == C_PRE) begin
            if (written_next >= PRE_CNT) state_d = C_WAIT;
          end else if (state_q == C_WAIT) begin
            if (trig_fire(bus.trig_mode, prev_trig_q, cur)) begin
              trig_seen_d = 1'b1;
              post_d      = cnt_t'(1);
              state_d     = C_POST;
            end
          end else begin
            post_d = post_q + 1'b1;
            if (post_q + 1'b1 == POST_CNT) begin
              state_d = C_ALIGN;
              rot_d   = wp_next;
              np_d    = 10'(DEPTH);
            end
          end
        end
      end
      C_ALIGN: begin
        if (rot_q != '0) begin
          mem_shift = 1'b1;
          rot_d     = rot_q - 1'b1;
        end
        if (rot_q <= addr_t'(1)) state_d = C_DONE;
      end
      default: state_d = C_IDLE;
    endcase
  end

  assign busy_d = state_d inside {C_PRE, C_WAIT, C_POST, C_ALIGN};
  assign done_d = state_d == C_DONE;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= C_IDLE;
      wp_q        <= '0;
      written_q   <= '0;
      post_q      <= '0;
      rot_q       <= '0;
      np_q        <= '0;
      trig_seen_q <= 1'b0;
      prev_trig_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      wp_q        <= wp_d;
      written_q   <= written_d;
      post_q      <= post_d;
      rot_q       <= rot_d;
      np_q        <= np_d;
      trig_seen_q <= trig_seen_d;
      prev_trig_q <= prev_trig_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  // NOTE: the buffer sits in flops with async reset so a reset discards any partial capture.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < DEPTH; k++) mem_q[k] <= '0;
    end else if (mem_shift) begin
      for (int k = 0; k < DEPTH; k++) mem_q[k] <= mem_q[(k + 1) % DEPTH];
    end else if (tick_en && tick) begin
      mem_q[wp_q] <= bus.din;
    end
  end

  always_comb begin
    for (int k = 0; k < DEPTH; k++) bus.ch[k] = mem_q[k][bus.rd_ch];
  end

  assign bus.np        = np_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.trig_seen = trig_seen_q;
endmodule

// File: tb/tb_logic_capture.sv
// Directed bench for logic_capture at DEPTH=16, PRE_DEPTH=4.
module tb_logic_capture;
  import pkg_capture::*;

  localparam int CH_NUM    = 8;
  localparam int DEPTH     = 16;
  localparam int PRE_DEPTH = 4;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;
  int   cycles;
  logic [DEPTH-1:0] chv;
  logic [7:0] v4 [7];

  logic_capture_if #(.CH_NUM(CH_NUM), .DEPTH(DEPTH)) bus ();

  logic_capture #(.CH_NUM(CH_NUM), .DEPTH(DEPTH), .PRE_DEPTH(PRE_DEPTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  always_comb begin
    for (int k = 0; k < DEPTH; k++) chv[k] = bus.ch[k];
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic arm_pulse(input logic [7:0] d);
    @(negedge clk);
    bus.din = d;
    bus.arm = 1'b1;
    @(negedge clk);
    bus.arm = 1'b0;
  endtask

  // Counts negedges until done; optionally drives din with the running count.
  task automatic wait_done(input string tag, input int budget, input bit count_din, output int n);
    n = 0;
    while (bus.done !== 1'b1 && n < budget) begin
      @(negedge clk);
      n++;
      if (count_din) bus.din = 8'(n);
    end
    check(tag, 32'(bus.done), 32'd1);
  endtask

  initial begin
    bus.din = '0; bus.arm = 1'b0; bus.stop = 1'b0; bus.trig_ch = '0;
    bus.rd_ch = '0; bus.trig_mode = TM_RISE; bus.div = '0;
    v4 = '{8'h20, 8'h00, 8'h20, 8'h20, 8'h00, 8'h00, 8'h20};

    // Reset state
    #12;
    check("rst_np",        32'(bus.np),        32'd0);
    check("rst_busy",      32'(bus.busy),      32'd0);
    check("rst_done",      32'(bus.done),      32'd0);
    check("rst_trig_seen", 32'(bus.trig_seen), 32'd0);
    check("rst_ch",        32'(chv),           32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // T1: rising edge on ch0 at sample 10, buffer wraps, rotate by 6
    arm_pulse(8'h00);
    check("t1_busy", 32'(bus.busy), 32'd1);
    repeat (9) @(negedge clk);
    @(negedge clk);
    bus.din = 8'h01;
    wait_done("t1_done", 100, 1'b0, cycles);
    check("t1_latency",  32'(cycles),        32'd18);
    check("t1_ch",       32'(chv),           32'h0000_FFF0);
    check("t1_ch4",      32'(chv[4]),        32'd1);
    check("t1_ch3",      32'(chv[3]),        32'd0);
    check("t1_np",       32'(bus.np),        32'd16);
    check("t1_trig",     32'(bus.trig_seen), 32'd1);
    check("t1_busy_end", 32'(bus.busy),      32'd0);

    // T2: div=3, immediate trigger, din counts every clk; sample j holds 4j+3
    bus.div = 16'd3;
    bus.trig_mode = TM_IMM;
    arm_pulse(8'h00);
    wait_done("t2_done", 200, 1'b1, cycles);
    check("t2_latency", 32'(cycles), 32'd65);
    bus.rd_ch = 3'd0;
    #1 check("t2_ch_bit0", 32'(chv), 32'h0000_FFFF);
    bus.rd_ch = 3'd2;
    #1 check("t2_ch_bit2", 32'(chv), 32'h0000_AAAA);
    bus.rd_ch = 3'd3;
    #1 check("t2_ch_bit3", 32'(chv), 32'h0000_CCCC);
    check("t2_np",   32'(bus.np),        32'd16);
    check("t2_trig", 32'(bus.trig_seen), 32'd1);

    // T3: falling edge on ch2 after 30 high samples, rotate by 10
    @(negedge clk);
    bus.div = 16'd0;
    bus.trig_mode = TM_FALL;
    bus.trig_ch = 3'd2;
    bus.rd_ch = 3'd2;
    arm_pulse(8'h04);
    repeat (29) @(negedge clk);
    @(negedge clk);
    bus.din = 8'h00;
    wait_done("t3_done", 100, 1'b0, cycles);
    check("t3_latency", 32'(cycles),        32'd22);
    check("t3_ch",      32'(chv),           32'h0000_000F);
    check("t3_np",      32'(bus.np),        32'd16);
    check("t3_trig",    32'(bus.trig_seen), 32'd1);

    // T4: no trigger, stop on the 7th sample
    @(negedge clk);
    bus.trig_mode = TM_RISE;
    bus.trig_ch = 3'd0;
    bus.rd_ch = 3'd5;
    arm_pulse(v4[0]);
    for (int i = 1; i < 7; i++) begin
      @(negedge clk);
      bus.din = v4[i];
      if (i == 6) bus.stop = 1'b1;
    end
    @(negedge clk);
    bus.stop = 1'b0;
    wait_done("t4_done", 20, 1'b0, cycles);
    check("t4_align_rot0", 32'(cycles),        32'd1);
    check("t4_np",         32'(bus.np),        32'd7);
    check("t4_trig",       32'(bus.trig_seen), 32'd0);
    check("t4_ch",         32'(chv[6:0]),      32'h4D);

    // T5: reset during POST, then a clean capture
    @(negedge clk);
    bus.trig_mode = TM_IMM;
    bus.rd_ch = 3'd0;
    arm_pulse(8'hFF);
    repeat (7) @(negedge clk);
    check("t5_busy_post", 32'(bus.busy), 32'd1);
    rst_n = 1'b0;
    #1;
    check("t5_rst_np",   32'(bus.np),        32'd0);
    check("t5_rst_busy", 32'(bus.busy),      32'd0);
    check("t5_rst_done", 32'(bus.done),      32'd0);
    check("t5_rst_trig", 32'(bus.trig_seen), 32'd0);
    check("t5_rst_ch",   32'(chv),           32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("t5_idle_busy", 32'(bus.busy), 32'd0);
    arm_pulse(8'h81);
    wait_done("t5_done", 100, 1'b0, cycles);
    check("t5_latency", 32'(cycles),        32'd17);
    check("t5_ch",      32'(chv),           32'h0000_FFFF);
    check("t5_np",      32'(bus.np),        32'd16);
    check("t5_trig",    32'(bus.trig_seen), 32'd1);

    // T6: trigger and stop on the same tick
    @(negedge clk);
    bus.trig_mode = TM_RISE;
    bus.trig_ch = 3'd1;
    bus.rd_ch = 3'd1;
    arm_pulse(8'h00);
    repeat (5) @(negedge clk);
    @(negedge clk);
    bus.din = 8'h02;
    bus.stop = 1'b1;
    @(negedge clk);
    bus.stop = 1'b0;
    wait_done("t6_done", 20, 1'b0, cycles);
    check("t6_trig", 32'(bus.trig_seen), 32'd0);
    check("t6_np",   32'(bus.np),        32'd7);
    check("t6_ch",   32'(chv[6:0]),      32'h40);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
